// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared types and constants for the CPU I/O port peripherals
package io_pkg;

    localparam int IO_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FIRE       = 2'd1,
        WAIT_EMPTY = 2'd2
    } int_state_t;

endpackage

// File: rtl/io_in_port_if.sv
// rtl/io_in_port_if.sv - producer and CPU-side signal bundle for the input port
interface io_in_port_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] ext_data;
    logic              ext_valid;
    logic              ext_ready;
    logic              cpu_rd;
    logic              int_en;
    logic [DATA_W-1:0] i_port;
    logic              int_sig;
    logic [CW-1:0]     count;
    logic              rd_underflow;

    modport master (
        output ext_data, ext_valid, cpu_rd, int_en,
        input  ext_ready, i_port, int_sig, count, rd_underflow
    );

    modport slave (
        input  ext_data, ext_valid, cpu_rd, int_en,
        output ext_ready, i_port, int_sig, count, rd_underflow
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - power-of-two synchronous FIFO with occupancy count
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // Full and empty come from the registered count only, so a pop never frees a slot in the same cycle.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage array carries no reset; stale entries are hidden by the empty gate on rdata.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_in_port.sv
// rtl/io_in_port.sv - buffered CPU input port with sticky underflow and edge/level interrupt
module io_in_port
    import io_pkg::*;
#(
    parameter int DATA_W    = IO_DATA_W,
    parameter int DEPTH     = 4,
    parameter int INT_LEVEL = 0
) (
    input  logic           clk,
    input  logic           rst,
    io_in_port_if.slave    bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;
    logic [CW-1:0]     occ;
    logic              underflow;
    int_state_t        state;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.ext_valid),
        .pop   (bus.cpu_rd),
        .wdata (bus.ext_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (occ)
    );

    assign bus.ext_ready    = ~full;
    assign bus.i_port       = head;
    assign bus.count        = occ;
    assign bus.rd_underflow = underflow;
    assign bus.int_sig      = (INT_LEVEL != 0) ? (bus.int_en & ~empty) : (state == FIRE);

    // Sticky record of any pop attempted against an empty FIFO; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (bus.cpu_rd && empty) begin
            underflow <= 1'b1;
        end
    end

    // One-shot interrupt per empty->non-empty episode; parked in IDLE when level mode is chosen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (INT_LEVEL != 0) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:       if (!empty && bus.int_en) state <= FIRE;
                FIRE:       state <= WAIT_EMPTY;
                WAIT_EMPTY: if (empty) state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_in_port.sv
// tb/tb_io_in_port.sv - scoreboard bench driving edge- and level-interrupt ports in parallel
module tb_io_in_port;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ext_data;
    logic       ext_valid;
    logic       cpu_rd;
    logic       int_en;

    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    logic       uf_model = 1'b0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    io_in_port_if #(.DATA_W(8), .DEPTH(DEPTH)) bus_e ();
    io_in_port_if #(.DATA_W(8), .DEPTH(DEPTH)) bus_l ();

    assign bus_e.ext_data  = ext_data;
    assign bus_e.ext_valid = ext_valid;
    assign bus_e.cpu_rd    = cpu_rd;
    assign bus_e.int_en    = int_en;
    assign bus_l.ext_data  = ext_data;
    assign bus_l.ext_valid = ext_valid;
    assign bus_l.cpu_rd    = cpu_rd;
    assign bus_l.int_en    = int_en;

    io_in_port #(.DATA_W(8), .DEPTH(DEPTH), .INT_LEVEL(0)) u_edge (
        .clk (clk),
        .rst (rst),
        .bus (bus_e)
    );

    io_in_port #(.DATA_W(8), .DEPTH(DEPTH), .INT_LEVEL(1)) u_level (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; outputs are compared at the falling edge before the rising edge commits.
    task automatic step(input logic v, input logic [7:0] d, input logic rd, input logic en);
        logic       do_push;
        logic       do_pop;
        logic [7:0] exp_byte;
        @(negedge clk);
        ext_valid = v;
        ext_data  = d;
        cpu_rd    = rd;
        int_en    = en;
        #1;
        check("count_e", 32'(bus_e.count), sb.size());
        check("count_l", 32'(bus_l.count), sb.size());
        check("ready_e", 32'(bus_e.ext_ready), 32'(sb.size() != DEPTH));
        check("ready_l", 32'(bus_l.ext_ready), 32'(sb.size() != DEPTH));
        check("irq_lvl", 32'(bus_l.int_sig), 32'(en && sb.size() != 0));
        check("uflow_e", 32'(bus_e.rd_underflow), 32'(uf_model));
        check("uflow_l", 32'(bus_l.rd_underflow), 32'(uf_model));
        do_push = v && (sb.size() != DEPTH);
        do_pop  = rd && (sb.size() != 0);
        if (do_pop) begin
            exp_byte = sb.pop_front();
            check("pop_e", 32'(bus_e.i_port), 32'(exp_byte));
            check("pop_l", 32'(bus_l.i_port), 32'(exp_byte));
        end else begin
            exp_byte = (sb.size() != 0) ? sb[0] : 8'h00;
            check("head_e", 32'(bus_e.i_port), 32'(exp_byte));
        end
        if (rd && !do_pop) uf_model = 1'b1;
        if (do_push) sb.push_back(d);
        if (bus_e.int_sig) pulses++;
        @(posedge clk);
    endtask

    // Two reset cycles with the producer still asserting valid; nothing may be captured.
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        ext_valid = 1'b1;
        ext_data  = 8'hEE;
        cpu_rd    = 1'b0;
        int_en    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", 32'(bus_e.ext_ready), 32'd1);
        check("rst_iport", 32'(bus_e.i_port), 32'd0);
        check("rst_count", 32'(bus_e.count), 32'd0);
        check("rst_irq_e", 32'(bus_e.int_sig), 32'd0);
        check("rst_irq_l", 32'(bus_l.int_sig), 32'd0);
        check("rst_uflow", 32'(bus_e.rd_underflow), 32'd0);
        rst       = 1'b0;
        ext_valid = 1'b0;
        sb.delete();
        uf_model  = 1'b0;
    endtask

    task automatic idle(input int n, input logic en);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, en);
    endtask

    initial begin
        rst = 1'b1; ext_valid = 1'b0; ext_data = '0; cpu_rd = 1'b0; int_en = 1'b0;

        do_reset();
        idle(1, 1'b0);

        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b1, 8'h44, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        idle(2, 1'b0);

        pulses = 0;
        step(1'b1, 8'hA5, 1'b0, 1'b1);
        idle(3, 1'b1);
        check("irq_first", pulses, 1);
        pulses = 0;
        step(1'b1, 8'h5A, 1'b0, 1'b1);
        idle(3, 1'b1);
        check("irq_nofire", pulses, 0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        idle(2, 1'b1);
        pulses = 0;
        step(1'b1, 8'h01, 1'b0, 1'b1);
        idle(3, 1'b1);
        check("irq_refire", pulses, 1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        idle(2, 1'b0);
        pulses = 0;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        idle(3, 1'b0);
        check("irq_masked", pulses, 0);
        idle(3, 1'b1);
        check("irq_unmask", pulses, 1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        idle(2, 1'b1);

        step(1'b0, 8'h00, 1'b1, 1'b1);
        idle(2, 1'b1);
        step(1'b1, 8'h66, 1'b1, 1'b1);
        step(1'b1, 8'h99, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        idle(2, 1'b1);
        step(1'b1, 8'hC1, 1'b0, 1'b1);
        step(1'b1, 8'hC2, 1'b0, 1'b1);
        do_reset();
        idle(2, 1'b1);

        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(8'h30 + i), (i != 0), (i % 3 != 0));
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(8'hB0 + i), 1'b0, (i % 2 == 0));
            step(1'b0, 8'h00, 1'b1, (i % 4 != 1));
        end
        step(1'b0, 8'h00, 1'b1, 1'b1);
        idle(2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
